// File: rtl/ads1278_frame_reader.sv
// ADS1278 SPI/TDM frame reader: generates SCLK and deserialises NUM_CH words from DOUT1
// after each DRDY falling edge, gated by the ADC clock PLL lock.
module ads1278_frame_reader #(
  parameter int SCLK_DIV    = 2,
  parameter int NUM_CH      = 8,
  parameter int DATA_BITS   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  input  logic                 adc_drdy_n,
  input  logic                 adc_dout,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] ch_data,
  output logic [2:0]           ch_idx,
  output logic                 ch_valid,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, WAIT_DRDY, SHIFT} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] drdy_sync, lock_sync;
  logic                   drdy_prev, drdy_s, lock_s, drdy_fall, dout_r;
  logic [HW-1:0]          half_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [2:0]             ch_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   half_tc, word_rdy, last_ch, shifting, fall_tick;

  // NOTE: every sequential block uses non-blocking assignments so that all flops
  // sample the pre-edge values of each other, independent of process order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drdy_sync <= '1;
      lock_sync <= '0;
      drdy_prev <= 1'b1;
      dout_r    <= 1'b0;
    end else begin
      drdy_sync[0] <= adc_drdy_n;
      lock_sync[0] <= pll_lock;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        drdy_sync[i] <= drdy_sync[i-1];
        lock_sync[i] <= lock_sync[i-1];
      end
      drdy_prev <= drdy_s;
      dout_r    <= adc_dout;
    end
  end

  assign drdy_s    = drdy_sync[SYNC_STAGES-1];
  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign drdy_fall = drdy_prev & ~drdy_s;

  assign half_tc   = (half_cnt == HW'(SCLK_DIV - 1));
  assign word_rdy  = (bit_cnt == BW'(DATA_BITS));
  assign last_ch   = (ch_cnt == 3'(NUM_CH - 1));
  assign shifting  = (state == SHIFT) && lock_s;
  assign fall_tick = shifting && half_tc && adc_sclk;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (lock_s) state_nx = WAIT_DRDY;
      WAIT_DRDY: if (!lock_s) state_nx = IDLE;
                 else if (drdy_fall) state_nx = SHIFT;
      SHIFT:     if (!lock_s) state_nx = IDLE;
                 else if (word_rdy && last_ch) state_nx = WAIT_DRDY;
      default:   state_nx = IDLE;
    endcase
  end

  // NOTE: the shift register has no reset; every bit is overwritten before it
  // reaches ch_data, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (fall_tick) shreg <= {shreg[DATA_BITS-2:0], dout_r};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_sclk   <= 1'b0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      ch_cnt     <= '0;
      ch_data    <= '0;
      ch_idx     <= '0;
      ch_valid   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      ch_valid   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= (state == SHIFT) && drdy_fall;
      if (shifting) begin
        if (half_tc) begin
          half_cnt <= '0;
          adc_sclk <= ~adc_sclk;
          if (adc_sclk) bit_cnt <= bit_cnt + BW'(1);
        end else begin
          half_cnt <= half_cnt + HW'(1);
        end
        // A falling tick never lands on the word_rdy cycle, so the clear wins cleanly.
        if (word_rdy) begin
          ch_data  <= shreg;
          ch_idx   <= ch_cnt;
          ch_valid <= 1'b1;
          bit_cnt  <= '0;
          if (last_ch) begin
            frame_done <= 1'b1;
            adc_sclk   <= 1'b0;
            ch_cnt     <= '0;
          end else begin
            ch_cnt <= ch_cnt + 3'd1;
          end
        end
      end else begin
        // Outside an active frame (including a lock-loss abort) SCLK parks low.
        adc_sclk <= 1'b0;
        half_cnt <= '0;
        bit_cnt  <= '0;
        ch_cnt   <= '0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: doc/ads1278_frame_reader.md
Name: ads1278_frame_reader

Overview:
- Reads one ADS1278 conversion frame per DRDY event, in SPI interface, TDM fixed-position format, from a single DOUT1 line.
- Sits directly downstream of the ads1278_clk PLL, whose 25 MHz CLKOUT drives the ADC CLK pin. The PLL lock gates this block.
- Generates SCLK from the system clock, deserialises 8 channels of 24-bit two's-complement data MSB-first, and presents one word per channel with a valid strobe to the 32x32 NIRS acquisition logic.

Parameters:
- SCLK_DIV, 2: system-clock cycles per SCLK half-period. Must be ≥1. With the default, SCLK = clk/4.
- NUM_CH, 8: channels per frame. Range 1..8.
- DATA_BITS, 24: bits per channel word.
- SYNC_STAGES, 2: synchroniser depth for drdy_n and pll_lock.

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- pll_lock, input, 1: lock output of the ADC clock PLL. Asynchronous; synchronised internally.
- adc_drdy_n, input, 1: ADS1278 DRDY, active low. Asynchronous; synchronised internally.
- adc_dout, input, 1: ADS1278 DOUT1. Registered once on input.
- adc_sclk, output, 1: SCLK to the ADC. Idle low.
- ch_data, output, DATA_BITS: channel word, sign bit at the MSB.
- ch_idx, output, 3: channel number of ch_data, 0..NUM_CH-1.
- ch_valid, output, 1: one-cycle strobe; ch_data and ch_idx are valid while it is high.
- frame_done, output, 1: one-cycle strobe after the last channel of a frame.
- overrun, output, 1: one-cycle strobe when a DRDY falling edge is detected while a frame is still shifting.
- busy, output, 1: high in the SHIFT state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - adc_sclk=0, ch_data=0, ch_idx=0, ch_valid=0, frame_done=0, overrun=0, busy=0.
  - All counters are cleared; the state becomes IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no partial word is emitted.
- Synchronisers:
  - drdy_s is adc_drdy_n after SYNC_STAGES flops.
  - lock_s is pll_lock after SYNC_STAGES flops.
  - drdy_fall = previous drdy_s is 1 and current drdy_s is 0 (one extra register).
- IDLE: stay while lock_s=0; go to WAIT_DRDY when lock_s=1.
- WAIT_DRDY: on drdy_fall, clear bit_cnt, ch_cnt and half_cnt, then go to SHIFT.
- SHIFT:
  - half_cnt counts 0..SCLK_DIV-1. At its terminal count adc_sclk toggles and half_cnt wraps to 0.
  - The first toggle (0→1) occurs SCLK_DIV cycles after entry.
  - On each 1→0 toggle (end of the high phase), shift the registered adc_dout into the shift register LSB-first-in, so the first bit received ends up as the MSB. Then increment bit_cnt.
  - When bit_cnt reaches DATA_BITS:
    - On the next clk, ch_data = shift register, ch_idx = ch_cnt, ch_valid = 1 for exactly one cycle.
    - bit_cnt resets to 0 and ch_cnt increments.
    - SCLK keeps running without a gap.
  - When ch_cnt reaches NUM_CH:
    - frame_done = 1 on the same cycle as the last ch_valid.
    - adc_sclk is held 0; the state returns to WAIT_DRDY.
- Timing: one frame is NUM_CH*DATA_BITS SCLK periods, i.e. 2*SCLK_DIV*NUM_CH*DATA_BITS clk cycles. The defaults give 768 cycles.
- drdy_fall during SHIFT:
  - overrun pulses for 1 cycle and the edge is ignored.
  - The current frame completes normally. No new frame starts until the next drdy_fall in WAIT_DRDY.
- drdy_fall on the same cycle the state returns to WAIT_DRDY counts as an overrun, not a start.
- lock_s falling in any state:
  - Go to IDLE on the next cycle with adc_sclk=0, busy=0, and no ch_valid/frame_done for the aborted frame.
  - A drdy_fall is accepted again only after lock_s=1 and the block has re-entered WAIT_DRDY.
- ch_data holds its last value between strobes.
- ch_idx wraps only via the frame reset to 0; it never exceeds NUM_CH-1.
- adc_sclk is a registered output: no combinational path from any input.

Test Plan:
- Reset and lock hold-off: hold rst_n=0 for 4 cycles with pll_lock=0. Then pulse adc_drdy_n low. Required: adc_sclk stays 0 and no ch_valid. After pll_lock=1, the next DRDY fall starts a frame and busy=1.
- Single frame, defaults: ADC model drives channel n = 24'h100000+n, changing on SCLK falling edges. Required:
  - 8 ch_valid strobes with ch_idx 0..7 and data 24'h100000..24'h100007.
  - Strobes are 96 cycles apart.
  - frame_done coincides with ch_idx=7.
  - 192 SCLK rising edges in total.
- Sign and extreme values: channels 24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h000000. Required: words captured bit-exact with MSB first.
- Overrun: issue a second DRDY fall 300 cycles into a frame. Required: one overrun pulse, the frame still delivers 8 words, and no second frame starts until the following DRDY fall.
- Lock loss mid-frame: drop pll_lock after the 3rd ch_valid. Required: within SYNC_STAGES+1 cycles adc_sclk=0 and busy=0; no further ch_valid and no frame_done. After relock and a DRDY fall, a clean frame starts at ch_idx=0.
- SCLK_DIV=1, NUM_CH=4: run a frame. Required: SCLK = clk/2, 4 words strobed 48 cycles apart, frame length 192 cycles.
